// File: rtl/option_menu.sv
// Battle-menu controller: N options on one row with an enable mask, key-driven highlight and
// decide commit, drawn as filled rectangles. Define MENU_TIMEOUT_EN to build the auto-commit timer.
module option_menu #(
    parameter int unsigned NUM_OPTIONS    = 4,
    parameter logic [3:0]  ENTER_STATE    = 4'b0000,
    parameter bit          WRAP           = 1'b1,
    parameter int unsigned BTN_X0         = 126,
    parameter int unsigned BTN_PITCH      = 206,
    parameter int unsigned BTN_Y          = 707,
    parameter int unsigned BTN_W          = 110,
    parameter int unsigned BTN_H          = 42,
    parameter logic [11:0] COLOR_SEL      = 12'hFF0,
    parameter logic [11:0] COLOR_IDLE     = 12'hF80,
    parameter logic [11:0] COLOR_DIS      = 12'h444,
    parameter int unsigned TIMEOUT_CYCLES = 32500000,
    localparam int unsigned IDX_W         = $clog2(NUM_OPTIONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic [3:0]             state_in,
    input  logic [NUM_OPTIONS-1:0] option_mask_in,
    input  logic [1:0]             key_input_in,
    input  logic                   decide_in,
    output logic                   busy_out,
    output logic                   finished_out,
    output logic [IDX_W-1:0]       choice_out,
    output logic                   timed_out_out,
    output logic [11:0]            pixel_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } menu_state_t;

    localparam logic [11:0] ROW_TOP = 12'(BTN_Y);
    localparam logic [11:0] ROW_BOT = 12'(BTN_Y + BTN_H);
    localparam logic [11:0] BTN_W12 = 12'(BTN_W);

    menu_state_t      state, state_next;
    logic [IDX_W-1:0] sel_idx, sel_next;
    logic [3:0]       prev_state;
    logic [1:0]       prev_key;
    logic             prev_decide;

    logic             entry_edge, key_edge, decide_edge, sel_enabled, commit;
    logic [IDX_W-1:0] lowest_idx, up_idx, dn_idx;
    logic             up_found, dn_found;
    int unsigned      sel_u, cand_up, cand_dn;

    logic [11:0]      h12, v12, btn_left, pix_next;
    logic             in_row;

`ifdef MENU_TIMEOUT_EN
    logic [31:0]      tmo_cnt;
    logic             tmo_hit, tmo_clr, commit_tmo;

    assign tmo_hit = (state == ACTIVE) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`endif

    assign entry_edge  = (state_in == ENTER_STATE) && (prev_state != ENTER_STATE);
    assign key_edge    = (prev_key == 2'b00) && (key_input_in != 2'b00);
    assign decide_edge = !prev_decide && decide_in;
    assign sel_enabled = option_mask_in[sel_idx];

    always_comb begin
        lowest_idx = '0;
        for (int unsigned i = NUM_OPTIONS; i > 0; i--) begin
            if (option_mask_in[IDX_W'(i - 1)]) lowest_idx = IDX_W'(i - 1);
        end
    end

    // Nearest enabled neighbour in each direction; out-of-range candidates (no wrap) mark "none".
    always_comb begin
        up_idx   = sel_idx;
        dn_idx   = sel_idx;
        up_found = 1'b0;
        dn_found = 1'b0;
        sel_u    = 32'(sel_idx);
        cand_up  = 0;
        cand_dn  = 0;
        for (int unsigned k = 1; k < NUM_OPTIONS; k++) begin
            cand_up = sel_u + k;
            if (WRAP && cand_up >= NUM_OPTIONS) cand_up = cand_up - NUM_OPTIONS;
            if (WRAP) begin
                cand_dn = sel_u + NUM_OPTIONS - k;
                if (cand_dn >= NUM_OPTIONS) cand_dn = cand_dn - NUM_OPTIONS;
            end else if (k <= sel_u) begin
                cand_dn = sel_u - k;
            end else begin
                cand_dn = NUM_OPTIONS;
            end
            if (!up_found && cand_up < NUM_OPTIONS && option_mask_in[IDX_W'(cand_up)]) begin
                up_idx   = IDX_W'(cand_up);
                up_found = 1'b1;
            end
            if (!dn_found && cand_dn < NUM_OPTIONS && option_mask_in[IDX_W'(cand_dn)]) begin
                dn_idx   = IDX_W'(cand_dn);
                dn_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel_idx;
        commit     = 1'b0;
`ifdef MENU_TIMEOUT_EN
        commit_tmo = 1'b0;
        tmo_clr    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (entry_edge && (|option_mask_in)) begin
                    state_next = ACTIVE;
                    sel_next   = lowest_idx;
`ifdef MENU_TIMEOUT_EN
                    tmo_clr    = 1'b1;
`endif
                end
            end
            ACTIVE: begin
                // Abort beats commit; decide beats a simultaneous key press.
                if (state_in != ENTER_STATE) begin
                    state_next = IDLE;
                end else if (decide_edge && sel_enabled) begin
                    commit     = 1'b1;
                    state_next = IDLE;
`ifdef MENU_TIMEOUT_EN
                end else if (tmo_hit && sel_enabled) begin
                    commit     = 1'b1;
                    commit_tmo = 1'b1;
                    state_next = IDLE;
`endif
                end else if (key_edge) begin
                    if (key_input_in == 2'b01)      sel_next = up_idx;
                    else if (key_input_in == 2'b10) sel_next = dn_idx;
                end
`ifdef MENU_TIMEOUT_EN
                if (key_edge || decide_edge || tmo_hit) tmo_clr = 1'b1;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        h12      = {1'b0, hcount_in};
        v12      = {2'b00, vcount_in};
        in_row   = (v12 >= ROW_TOP) && (v12 < ROW_BOT);
        btn_left = '0;
        pix_next = '0;
        for (int unsigned i = 0; i < NUM_OPTIONS; i++) begin
            btn_left = 12'(BTN_X0 + i * BTN_PITCH);
            if (busy_out && in_row && h12 >= btn_left && h12 < btn_left + BTN_W12) begin
                if (sel_idx == IDX_W'(i))             pix_next = COLOR_SEL;
                else if (option_mask_in[IDX_W'(i)])   pix_next = COLOR_IDLE;
                else                                  pix_next = COLOR_DIS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sel_idx      <= '0;
            busy_out     <= 1'b0;
            finished_out <= 1'b0;
            choice_out   <= '0;
            pixel_out    <= '0;
            prev_state   <= ~ENTER_STATE;
            prev_key     <= 2'b00;
            prev_decide  <= 1'b0;
        end else begin
            state        <= state_next;
            sel_idx      <= sel_next;
            busy_out     <= (state_next == ACTIVE);
            finished_out <= commit;
            if (commit) choice_out <= sel_idx;
            pixel_out    <= pix_next;
            prev_state   <= state_in;
            prev_key     <= key_input_in;
            prev_decide  <= decide_in;
        end
    end

`ifdef MENU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt       <= '0;
            timed_out_out <= 1'b0;
        end else begin
            timed_out_out <= commit_tmo;
            if (tmo_clr)               tmo_cnt <= '0;
            else if (state == ACTIVE)  tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    assign timed_out_out = 1'b0;
`endif

endmodule

// File: tb/tb_option_menu.sv
// Directed bench for option_menu: a per-cycle vector table on a wrapping instance, plus
// hand sequences comparing wrap vs clamp navigation, reset, and the auto-commit timer.
module tb_option_menu;

    localparam logic [3:0]  E   = 4'b0000;
    localparam logic [3:0]  O   = 4'b0101;
    localparam logic [11:0] SEL = 12'hFF0;
    localparam logic [11:0] IDL = 12'hF80;
    localparam logic [11:0] DIS = 12'h444;
    localparam logic [10:0] H0 = 11'd130, H1 = 11'd336, H2 = 11'd542, H3 = 11'd748;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [3:0]  st;
    logic [3:0]  mask;
    logic [1:0]  key;
    logic        dec;

    logic        w_busy, w_fin, w_tout, c_busy, c_fin, c_tout;
    logic [1:0]  w_ch, c_ch;
    logic [11:0] w_pix, c_pix;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    option_menu #(.NUM_OPTIONS(4), .WRAP(1'b1), .TIMEOUT_CYCLES(16)) u_wrap (
        .clk(clk), .rst(rst), .hcount_in(hc), .vcount_in(vc), .state_in(st),
        .option_mask_in(mask), .key_input_in(key), .decide_in(dec),
        .busy_out(w_busy), .finished_out(w_fin), .choice_out(w_ch),
        .timed_out_out(w_tout), .pixel_out(w_pix)
    );

    option_menu #(.NUM_OPTIONS(4), .WRAP(1'b0), .TIMEOUT_CYCLES(16)) u_clamp (
        .clk(clk), .rst(rst), .hcount_in(hc), .vcount_in(vc), .state_in(st),
        .option_mask_in(mask), .key_input_in(key), .decide_in(dec),
        .busy_out(c_busy), .finished_out(c_fin), .choice_out(c_ch),
        .timed_out_out(c_tout), .pixel_out(c_pix)
    );

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  mask;
        logic [1:0]  key;
        logic        dec;
        logic [10:0] h;
        logic [9:0]  v;
        logic        busy;
        logic        fin;
        logic [1:0]  ch;
        logic [11:0] pix;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] s, input logic [3:0] m, input logic [1:0] k,
                                input logic d, input logic [10:0] h, input logic [9:0] v,
                                input logic b, input logic f, input logic [1:0] c,
                                input logic [11:0] p);
        vec_t x;
        x.st = s; x.mask = m; x.key = k; x.dec = d; x.h = h; x.v = v;
        x.busy = b; x.fin = f; x.ch = c; x.pix = p;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] k);
        key = k;
        tick();
        key = 2'b00;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        st = O; mask = 4'b1111; key = 2'b00; dec = 1'b0; hc = H0; vc = 10'd710;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        chk("rst_busy",  32'(w_busy), 32'd0);
        chk("rst_fin",   32'(w_fin),  32'd0);
        chk("rst_choice",32'(w_ch),   32'd0);
        chk("rst_pix",   32'(w_pix),  32'd0);
        chk("rst_tout",  32'(w_tout), 32'd0);

        // entry, pixel latency and rectangle boundaries (mask 1111, sel 0)
        add(O, 4'b1111, 2'd0, 0, H0, 710, 0, 0, 2'd0, 12'h000);
        add(E, 4'b1111, 2'd0, 0, H0, 710, 1, 0, 2'd0, 12'h000);
        add(E, 4'b1111, 2'd0, 0, H0, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1111, 2'd0, 0, H1, 710, 1, 0, 2'd0, IDL);
        add(E, 4'b1111, 2'd0, 0, 125, 710, 1, 0, 2'd0, 12'h000);
        add(E, 4'b1111, 2'd0, 0, 126, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1111, 2'd0, 0, 235, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1111, 2'd0, 0, 236, 710, 1, 0, 2'd0, 12'h000);
        add(E, 4'b1111, 2'd0, 0, H0, 706, 1, 0, 2'd0, 12'h000);
        add(E, 4'b1111, 2'd0, 0, H0, 707, 1, 0, 2'd0, SEL);
        add(E, 4'b1111, 2'd0, 0, H0, 748, 1, 0, 2'd0, SEL);
        add(E, 4'b1111, 2'd0, 0, H0, 749, 1, 0, 2'd0, 12'h000);
        add(E, 4'b1111, 2'd0, 0, 853, 710, 1, 0, 2'd0, IDL);
        add(E, 4'b1111, 2'd0, 0, 854, 710, 1, 0, 2'd0, 12'h000);
        // mask 1011: skip disabled option, wrap both ways, held and 11 keys
        add(E, 4'b1011, 2'd0, 0, H2, 710, 1, 0, 2'd0, DIS);
        add(E, 4'b1011, 2'd1, 0, H0, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd0, 0, H1, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd1, 0, H1, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd0, 0, H3, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd1, 0, H3, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd0, 0, H0, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd2, 0, H0, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd0, 0, H3, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd1, 0, H3, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd1, 0, H0, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd0, 0, H0, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd3, 0, H0, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1011, 2'd0, 0, H0, 710, 1, 0, 2'd0, SEL);
        // move to idx2 and commit; held decide and held state do not re-arm
        add(E, 4'b1111, 2'd1, 0, H0, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1111, 2'd0, 0, H1, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1111, 2'd1, 0, H1, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1111, 2'd0, 0, H2, 710, 1, 0, 2'd0, SEL);
        add(E, 4'b1111, 2'd0, 1, H2, 710, 0, 1, 2'd2, SEL);
        add(E, 4'b1111, 2'd0, 1, H2, 710, 0, 0, 2'd2, 12'h000);
        add(E, 4'b1111, 2'd0, 0, H2, 710, 0, 0, 2'd2, 12'h000);
        // re-arm, then key and decide edges together at idx1
        add(O, 4'b1111, 2'd0, 0, H2, 710, 0, 0, 2'd2, 12'h000);
        add(E, 4'b1111, 2'd0, 0, H0, 710, 1, 0, 2'd2, 12'h000);
        add(E, 4'b1111, 2'd1, 0, H0, 710, 1, 0, 2'd2, SEL);
        add(E, 4'b1111, 2'd0, 0, H1, 710, 1, 0, 2'd2, SEL);
        add(E, 4'b1111, 2'd1, 1, H1, 710, 0, 1, 2'd1, SEL);
        add(E, 4'b1111, 2'd0, 0, H1, 710, 0, 0, 2'd1, 12'h000);
        // abort, then entry with empty mask
        add(O, 4'b1111, 2'd0, 0, H0, 710, 0, 0, 2'd1, 12'h000);
        add(E, 4'b1111, 2'd0, 0, H0, 710, 1, 0, 2'd1, 12'h000);
        add(4'b0011, 4'b1111, 2'd0, 0, H0, 710, 0, 0, 2'd1, SEL);
        add(4'b0011, 4'b1111, 2'd0, 0, H0, 710, 0, 0, 2'd1, 12'h000);
        add(E, 4'b0000, 2'd0, 0, H0, 710, 0, 0, 2'd1, 12'h000);
        add(E, 4'b1111, 2'd0, 0, H0, 710, 0, 0, 2'd1, 12'h000);
        // entry lands on lowest enabled; decide on a disabled highlight is ignored
        add(O, 4'b1111, 2'd0, 0, H0, 710, 0, 0, 2'd1, 12'h000);
        add(E, 4'b1110, 2'd0, 0, H1, 710, 1, 0, 2'd1, 12'h000);
        add(E, 4'b1110, 2'd0, 0, H1, 710, 1, 0, 2'd1, SEL);
        add(E, 4'b1100, 2'd0, 1, H1, 710, 1, 0, 2'd1, SEL);
        add(E, 4'b1100, 2'd0, 0, H1, 710, 1, 0, 2'd1, SEL);
        add(E, 4'b1100, 2'd1, 0, H1, 710, 1, 0, 2'd1, SEL);
        add(E, 4'b1100, 2'd0, 1, H2, 710, 0, 1, 2'd2, SEL);
        add(E, 4'b1100, 2'd0, 0, H2, 710, 0, 0, 2'd2, 12'h000);

        for (int i = 0; i < vecs.size(); i++) begin
            st = vecs[i].st; mask = vecs[i].mask; key = vecs[i].key; dec = vecs[i].dec;
            hc = vecs[i].h;  vc = vecs[i].v;
            tick();
            chk($sformatf("v%0d_busy", i),   32'(w_busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_fin", i),    32'(w_fin),  32'(vecs[i].fin));
            chk($sformatf("v%0d_choice", i), 32'(w_ch),   32'(vecs[i].ch));
            chk($sformatf("v%0d_pix", i),    32'(w_pix),  32'(vecs[i].pix));
            chk($sformatf("v%0d_tout", i),   32'(w_tout), 32'd0);
        end

        // wrap vs clamp on mask 1011
        do_reset();
        chk("rst2_choice", 32'(w_ch), 32'd0);
        chk("rst2_busy_clamp", 32'(c_busy), 32'd0);
        mask = 4'b1011;
        tick();
        st = E;
        tick();
        chk("arm_busy_clamp", 32'(c_busy), 32'd1);
        press(2'b01);
        hc = H1; tick();
        chk("p1_wrap", 32'(w_pix), 32'(SEL));
        chk("p1_clamp", 32'(c_pix), 32'(SEL));
        press(2'b01);
        hc = H3; tick();
        chk("p2_wrap", 32'(w_pix), 32'(SEL));
        chk("p2_clamp", 32'(c_pix), 32'(SEL));
        press(2'b01);
        hc = H0; tick();
        chk("p3_wrap_at0", 32'(w_pix), 32'(SEL));
        chk("p3_clamp_at0", 32'(c_pix), 32'(IDL));
        hc = H3; tick();
        chk("p3_wrap_at3", 32'(w_pix), 32'(IDL));
        chk("p3_clamp_at3", 32'(c_pix), 32'(SEL));
        press(2'b10);
        hc = H3; tick();
        chk("d1_wrap", 32'(w_pix), 32'(SEL));
        hc = H1; tick();
        chk("d1_clamp", 32'(c_pix), 32'(SEL));
        press(2'b10);
        press(2'b10);
        hc = H0; tick();
        chk("d3_wrap", 32'(w_pix), 32'(SEL));
        chk("d3_clamp", 32'(c_pix), 32'(SEL));

        do_reset();
        tick();
        st = E;
        tick();
        chk("tmo_arm", 32'(w_busy), 32'd1);
`ifdef MENU_TIMEOUT_EN
        for (int n = 1; n < 16; n++) begin
            tick();
            chk($sformatf("tmo_wait%0d", n), 32'(w_fin), 32'd0);
        end
        tick();
        chk("tmo_fin", 32'(w_fin), 32'd1);
        chk("tmo_tout", 32'(w_tout), 32'd1);
        chk("tmo_busy", 32'(w_busy), 32'd0);
        chk("tmo_choice", 32'(w_ch), 32'd0);
        tick();
        chk("tmo_fin_once", 32'(w_fin), 32'd0);
        chk("tmo_tout_once", 32'(w_tout), 32'd0);
`else
        for (int n = 0; n < 40; n++) tick();
        chk("notmo_busy", 32'(w_busy), 32'd1);
        chk("notmo_fin", 32'(w_fin), 32'd0);
        chk("notmo_tout", 32'(w_tout), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
